ctx_switcher: RTL and testbench

CTX_SWITCHER -- requirements
Module: ctx_switcher

---
 rtl/ctx_switcher.sv | 134 +++++++++++++
 tb/tb_ctx_switcher.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctx_switcher.sv
// Context switcher: saves the live register file into one of NCTX slots and/or
// reloads a slot into the register file through one-cycle bulk strobes.
module ctx_switcher #(
  parameter int unsigned NCTX = 4,
  parameter int unsigned SW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_save,
  input  logic            req_load,
  input  logic [SW-1:0]   save_slot,
  input  logic [SW-1:0]   load_slot,
  output logic            done,
  output logic            err,
  output logic            give_me,
  input  logic [255:0]    the_regs,
  output logic            writing_regs,
  output logic [255:0]    change_me,
  input  logic            init_wen,
  input  logic [SW-1:0]   init_slot,
  input  logic [255:0]    init_data,
  output logic [NCTX-1:0] slot_valid
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_REQ,
    SAVE_CAP,
    LOAD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic            load_q, load_d;
  logic [SW-1:0]   save_slot_q, save_slot_d;
  logic [SW-1:0]   load_slot_q, load_slot_d;
  logic            err_q, err_d;
  logic [NCTX-1:0] slot_valid_q, slot_valid_d;

  logic [255:0]    mem_q [NCTX];
  logic            mem_we;
  logic [SW-1:0]   mem_waddr;
  logic [255:0]    mem_wdata;

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    save_slot_d  = save_slot_q;
    load_slot_d  = load_slot_q;
    err_d        = err_q;
    slot_valid_d = slot_valid_q;
    mem_we       = 1'b0;
    mem_waddr    = save_slot_q;
    mem_wdata    = the_regs;
    req_ready    = 1'b0;
    give_me      = 1'b0;
    writing_regs = 1'b0;
    change_me    = '0;
    done         = 1'b0;
    err          = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        err_d     = 1'b0;
        // Host preload lands on the acceptance edge, so a load in the same
        // request already sees it when LOAD reads the slot.
        if (init_wen) begin
          mem_we                  = 1'b1;
          mem_waddr               = init_slot;
          mem_wdata               = init_data;
          slot_valid_d[init_slot] = 1'b1;
        end
        if (req_valid) begin
          load_d      = req_load;
          save_slot_d = save_slot;
          load_slot_d = load_slot;
          if (req_save)      state_d = SAVE_REQ;
          else if (req_load) state_d = LOAD;
          else               state_d = DONE;
        end
      end
      SAVE_REQ: begin
        give_me = 1'b1;
        state_d = SAVE_CAP;
      end
      SAVE_CAP: begin
        mem_we                    = 1'b1;
        slot_valid_d[save_slot_q] = 1'b1;
        state_d                   = load_q ? LOAD : DONE;
      end
      LOAD: begin
        writing_regs = 1'b1;
        if (slot_valid_q[load_slot_q]) change_me = mem_q[load_slot_q];
        else                           err_d     = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_q       <= 1'b0;
      save_slot_q  <= '0;
      load_slot_q  <= '0;
      err_q        <= 1'b0;
      slot_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      save_slot_q  <= save_slot_d;
      load_slot_q  <= load_slot_d;
      err_q        <= err_d;
      slot_valid_q <= slot_valid_d;
    end
  end

  // Slot storage is deliberately unreset; slot_valid gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign slot_valid = slot_valid_q;

endmodule

// File: tb/tb_ctx_switcher.sv
// Directed-vector and random-model bench for ctx_switcher.
module tb_ctx_switcher;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_ready;
  logic         req_save = 1'b0, req_load = 1'b0;
  logic [1:0]   save_slot = '0, load_slot = '0;
  logic         done, err, give_me, writing_regs;
  logic [255:0] the_regs = '0, change_me;
  logic         init_wen = 1'b0;
  logic [1:0]   init_slot = '0;
  logic [255:0] init_data = '0;
  logic [3:0]   slot_valid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ctx_switcher #(.NCTX(4), .SW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_save(req_save), .req_load(req_load),
    .save_slot(save_slot), .load_slot(load_slot),
    .done(done), .err(err),
    .give_me(give_me), .the_regs(the_regs),
    .writing_regs(writing_regs), .change_me(change_me),
    .init_wen(init_wen), .init_slot(init_slot), .init_data(init_data),
    .slot_valid(slot_valid)
  );

  localparam logic [255:0] P  = {32{8'h01}};
  localparam logic [255:0] R  = {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [255:0] Q  = {8{32'hDEADBEEF}};
  localparam logic [255:0] D  = {8{32'h5A5A0F0F}};
  localparam logic [255:0] XD = {8{32'hCAFEF00D}};

  typedef struct {
    logic         ini;
    logic [1:0]   islot;
    logic [255:0] idata;
    logic         sv;
    logic         ld;
    logic [1:0]   ss;
    logic [1:0]   ls;
    logic [255:0] regs;
    int           lat;
    logic [255:0] chg;
    logic         er;
    logic [3:0]   vld;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ready", 256'(req_ready), 256'(1));
    chk("rst_valid", 256'(slot_valid), 256'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [1:0] s, input logic [255:0] d, input logic [3:0] vld);
    @(negedge clk);
    init_wen = 1'b1; init_slot = s; init_data = d;
    @(posedge clk); #1;
    init_wen = 1'b0;
    chk("preload_valid", 256'(slot_valid), 256'(vld));
  endtask

  task automatic run_req(input logic ini, input logic [1:0] islot, input logic [255:0] idata,
                         input logic sv, input logic ld, input logic [1:0] ss, input logic [1:0] ls,
                         input logic [255:0] regs, input int lat, input logic [255:0] chg,
                         input logic er, input logic [3:0] vld);
    int wr_c;
    bit seen;
    @(negedge clk);
    init_wen = ini; init_slot = islot; init_data = idata;
    req_valid = 1'b1; req_save = sv; req_load = ld;
    save_slot = ss; load_slot = ls; the_regs = regs;
    chk("ready_at_req", 256'(req_ready), 256'(1));
    @(posedge clk); #1;
    init_wen = 1'b0; req_valid = 1'b0; req_save = 1'b0; req_load = 1'b0;
    wr_c = ld ? (sv ? 3 : 1) : 0;
    seen = 1'b0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      chk("give_me", 256'(give_me), 256'(sv && c == 1));
      chk("writing_regs", 256'(writing_regs), 256'(c == wr_c));
      chk("change_me", change_me, (c == wr_c) ? chg : '0);
      chk("done", 256'(done), 256'(c == lat));
      chk("err", 256'(err), 256'((c == lat) && er));
      chk("busy_ready", 256'(req_ready), 256'(0));
      if (done) seen = 1'b1;
      @(posedge clk); #1;
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout: got no done expected done in cycle %0d", lat);
    end
    chk("ready_after", 256'(req_ready), 256'(1));
    chk("slot_valid", 256'(slot_valid), 256'(vld));
  endtask

  logic [255:0] m_mem [4];
  logic [3:0]   m_vld;

  initial begin
    tbl[0] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd0, 2'd1, '0, 2, P,  1'b0, 4'b0010};
    tbl[1] = '{1'b0, 2'd0, '0, 1'b1, 1'b1, 2'd2, 2'd2, R,  4, R,  1'b0, 4'b0110};
    tbl[2] = '{1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd0, 2'd3, '0, 2, '0, 1'b1, 4'b0110};
    tbl[3] = '{1'b0, 2'd0, '0, 1'b0, 1'b0, 2'd0, 2'd0, '0, 1, '0, 1'b0, 4'b0110};
    tbl[4] = '{1'b0, 2'd0, '0, 1'b1, 1'b0, 2'd0, 2'd0, Q,  3, '0, 1'b0, 4'b0111};
    tbl[5] = '{1'b0, 2'd0, '0, 1'b1, 1'b1, 2'd3, 2'd0, R,  4, Q,  1'b0, 4'b1111};
    tbl[6] = '{1'b1, 2'd3, D,  1'b0, 1'b1, 2'd0, 2'd3, '0, 2, D,  1'b0, 4'b1111};
    tbl[7] = '{1'b0, 2'd0, '0, 1'b1, 1'b1, 2'd1, 2'd2, Q,  4, R,  1'b0, 4'b1111};

    #1;
    chk("rst_ready", 256'(req_ready), 256'(1));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_give_me", 256'(give_me), 256'(0));
    chk("rst_writing", 256'(writing_regs), 256'(0));
    chk("rst_change_me", change_me, '0);
    chk("rst_valid", 256'(slot_valid), 256'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    preload(2'd1, P, 4'b0010);
    for (int i = 0; i < 8; i++)
      run_req(tbl[i].ini, tbl[i].islot, tbl[i].idata, tbl[i].sv, tbl[i].ld, tbl[i].ss,
              tbl[i].ls, tbl[i].regs, tbl[i].lat, tbl[i].chg, tbl[i].er, tbl[i].vld);

    // Load from a slot emptied by reset.
    do_reset();
    run_req(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd0, 2'd3, '0, 2, '0, 1'b1, 4'b0000);

    // Reset landing in SAVE_CAP aborts the operation.
    @(negedge clk);
    req_valid = 1'b1; req_save = 1'b1; req_load = 1'b1;
    save_slot = 2'd1; load_slot = 2'd1; the_regs = R;
    @(posedge clk); #1;
    req_valid = 1'b0; req_save = 1'b0; req_load = 1'b0;
    chk("abort_give_me", 256'(give_me), 256'(1));
    @(posedge clk); #1;
    chk("abort_cap_give_me", 256'(give_me), 256'(0));
    chk("abort_cap_writing", 256'(writing_regs), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ready", 256'(req_ready), 256'(1));
    chk("abort_valid", 256'(slot_valid), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_write", 256'(writing_regs), 256'(0));
      chk("abort_no_done", 256'(done), 256'(0));
      chk("abort_idle_ready", 256'(req_ready), 256'(1));
      chk("abort_valid_hold", 256'(slot_valid), 256'(0));
    end

    // Busy-time request and busy-time init are both ignored.
    @(negedge clk);
    req_valid = 1'b1; req_save = 1'b1; req_load = 1'b1;
    save_slot = 2'd2; load_slot = 2'd1; the_regs = R;
    @(posedge clk); #1;
    req_valid = 1'b0; req_save = 1'b0; req_load = 1'b0;
    chk("busy_give_me", 256'(give_me), 256'(1));
    @(posedge clk); #1;
    @(negedge clk);
    init_wen = 1'b1; init_slot = 2'd0; init_data = XD;
    @(posedge clk); #1;
    init_wen = 1'b0;
    req_valid = 1'b1; req_load = 1'b1; load_slot = 2'd0;
    chk("busy_load_ready", 256'(req_ready), 256'(0));
    chk("busy_writing", 256'(writing_regs), 256'(1));
    chk("busy_change_me", change_me, '0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_load = 1'b0;
    chk("busy_done", 256'(done), 256'(1));
    chk("busy_err", 256'(err), 256'(1));
    @(posedge clk); #1;
    chk("busy_valid", 256'(slot_valid), 256'(4'b0100));
    @(posedge clk); #1;
    chk("busy_no_restart_ready", 256'(req_ready), 256'(1));
    chk("busy_no_restart_gm", 256'(give_me), 256'(0));
    chk("busy_no_restart_wr", 256'(writing_regs), 256'(0));

    // Random back-to-back requests against a slot model.
    do_reset();
    m_vld = '0;
    for (int i = 0; i < 100; i++) begin
      logic         ini, sv, ld, er;
      logic [1:0]   islot, ss, ls;
      logic [255:0] idata, regs, chg;
      int           lat;
      ini = ($urandom_range(0, 3) == 0);
      islot = 2'($urandom_range(0, 3));
      idata = rand256();
      sv = 1'($urandom_range(0, 1));
      ld = 1'($urandom_range(0, 1));
      ss = 2'($urandom_range(0, 3));
      ls = 2'($urandom_range(0, 3));
      regs = rand256();
      if (ini) begin m_mem[islot] = idata; m_vld[islot] = 1'b1; end
      if (sv)  begin m_mem[ss] = regs;     m_vld[ss] = 1'b1;    end
      chg = (ld && m_vld[ls]) ? m_mem[ls] : '0;
      er  = ld && !m_vld[ls];
      case ({sv, ld})
        2'b11:   lat = 4;
        2'b10:   lat = 3;
        2'b01:   lat = 2;
        default: lat = 1;
      endcase
      run_req(ini, islot, idata, sv, ld, ss, ls, regs, lat, chg, er, m_vld);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  always @(negedge clk) begin
    if (give_me && writing_regs) begin
      n_vec++; n_bad++;
      $display("FAIL strobe_overlap: got give_me=1 writing_regs=1 expected not both");
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
